// File: rtl/imm_ext_arbiter.sv
// Purpose: time-shares one external immediate extender between two decode
//          slots; each slot owns a one-entry response buffer.
// Latency: 1 cycle from request accept to rspN_valid.
// Backpressure: a FULL, non-draining buffer deasserts its reqN_ready without
//          blocking the other slot; drain-and-refill in one cycle is allowed.
// Ports:
//   clk, rst (sync, active-low), flush   - clock, reset, pipeline flush
//   reqN_valid/ready/inst_index/action   - per-slot extend requests
//   ext_inst_index, ext_action, ext_res  - shared extender operands / result
//   rspN_valid/ready/data                - per-slot extended immediates
module imm_ext_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [25:0] req0_inst_index,
  input  logic [1:0]  req0_action,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [25:0] req1_inst_index,
  input  logic [1:0]  req1_action,
  output logic [25:0] ext_inst_index,
  output logic [1:0]  ext_action,
  input  logic [31:0] ext_res,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data
);

  logic        full0, full1;
  logic [31:0] data0, data1;
  logic        ptr;          // slot favoured when both are eligible
  logic        elig0, elig1;
  logic        grant0, grant1;

  // Eligibility includes rst so nothing is granted while reset is held,
  // and lets a FULL buffer refill in the same cycle it is drained.
  always_comb begin
    elig0 = rst && !flush && req0_valid && (!full0 || rsp0_ready);
    elig1 = rst && !flush && req1_valid && (!full1 || rsp1_ready);
  end

  always_comb begin
    grant0 = elig0 && (!elig1 || !ptr);
    grant1 = elig1 && (!elig0 ||  ptr);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    ext_inst_index = 26'd0;
    ext_action     = 2'd0;
    if (grant0) begin
      ext_inst_index = req0_inst_index;
      ext_action     = req0_action;
    end else if (grant1) begin
      ext_inst_index = req1_inst_index;
      ext_action     = req1_action;
    end
  end

  assign rsp0_valid = full0;
  assign rsp1_valid = full1;
  // Data registers are zeroed whenever a buffer empties, so EMPTY reads 0.
  assign rsp0_data  = data0;
  assign rsp1_data  = data1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      full0 <= 1'b0;
      full1 <= 1'b0;
      data0 <= 32'd0;
      data1 <= 32'd0;
      ptr   <= 1'b0;
    end else if (flush) begin
      full0 <= 1'b0;
      full1 <= 1'b0;
      data0 <= 32'd0;
      data1 <= 32'd0;
    end else begin
      if (grant0) begin
        full0 <= 1'b1;
        data0 <= ext_res;
      end else if (full0 && rsp0_ready) begin
        full0 <= 1'b0;
        data0 <= 32'd0;
      end

      if (grant1) begin
        full1 <= 1'b1;
        data1 <= ext_res;
      end else if (full1 && rsp1_ready) begin
        full1 <= 1'b0;
        data1 <= 32'd0;
      end

      if (elig0 && elig1)
        ptr <= !ptr;
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
module tb_imm_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [25:0] req0_inst_index = '0, req1_inst_index = '0;
  logic [1:0]  req0_action = '0, req1_action = '0;
  logic [25:0] ext_inst_index;
  logic [1:0]  ext_action;
  logic [31:0] ext_res;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_data, rsp1_data;

  int total = 0;
  int bad   = 0;

  // Reference model state: expected buffer contents per slot and turn pointer.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          turn = 0;
  int          dut_grant;

  always #5 clk = ~clk;

  imm_ext_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_inst_index(req0_inst_index), .req0_action(req0_action),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_inst_index(req1_inst_index), .req1_action(req1_action),
    .ext_inst_index(ext_inst_index), .ext_action(ext_action), .ext_res(ext_res),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data)
  );

  // Behavioural immediate extender: 00 jump index, 01 zero-extend, 1x sign-extend.
  function automatic logic [31:0] extend(input logic [25:0] idx, input logic [1:0] act);
    if (act == 2'b00)      return {6'd0, idx};
    else if (act == 2'b01) return {16'd0, idx[15:0]};
    else                   return {{16{idx[15]}}, idx[15:0]};
  endfunction

  always_comb ext_res = extend(ext_inst_index, ext_action);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares response outputs against the expected buffer queues,
  // retires consumed entries and discards everything on flush/reset.
  always begin
    logic e0, e1;
    @(negedge clk);
    #3;
    e0 = (q0.size() != 0);
    e1 = (q1.size() != 0);
    chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, e0});
    chk("rsp0_data", rsp0_data, e0 ? q0[0] : 32'd0);
    chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, e1});
    chk("rsp1_data", rsp1_data, e1 ? q1[0] : 32'd0);
    if (!rst || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (e0 && rsp0_ready) void'(q0.pop_front());
      if (e1 && rsp1_ready) void'(q1.pop_front());
    end
  end

  // Stimulus: drive one cycle, check grant/extender outputs, push expectations.
  task automatic do_cycle(input logic r, input logic f,
                          input logic v0, input logic [25:0] i0, input logic [1:0] a0,
                          input logic v1, input logic [25:0] i1, input logic [1:0] a1,
                          input logic rr0, input logic rr1);
    logic el0, el1;
    int   g;
    @(negedge clk);
    #1;
    rst = r; flush = f;
    req0_valid = v0; req0_inst_index = i0; req0_action = a0;
    req1_valid = v1; req1_inst_index = i1; req1_action = a1;
    rsp0_ready = rr0; rsp1_ready = rr1;
    #1;
    el0 = r && !f && v0 && (q0.size() == 0 || rr0);
    el1 = r && !f && v1 && (q1.size() == 0 || rr1);
    if (el0 && el1)  g = turn;
    else if (el0)    g = 0;
    else if (el1)    g = 1;
    else             g = -1;
    dut_grant = req1_ready ? 1 : (req0_ready ? 0 : -1);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
    chk("ext_inst_index", {6'd0, ext_inst_index},
        g == 0 ? {6'd0, i0} : (g == 1 ? {6'd0, i1} : 32'd0));
    chk("ext_action", {30'd0, ext_action},
        g == 0 ? {30'd0, a0} : (g == 1 ? {30'd0, a1} : 32'd0));
    #2;
    if (!r) turn = 0;
    else if (el0 && el1) turn = 1 - turn;
    if (g == 0) q0.push_back(extend(i0, a0));
    if (g == 1) q1.push_back(extend(i1, a1));
  endtask

  task automatic idle(input logic rr0, input logic rr1);
    do_cycle(1, 0, 0, '0, '0, 0, '0, '0, rr0, rr1);
  endtask

  initial begin
    int exp_seq[4];
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;

    // Reset, then single sign-extend request.
    do_cycle(0, 0, 1, 26'h1, 2'b01, 1, 26'h2, 2'b01, 1, 1);
    do_cycle(0, 0, 0, '0, '0, 0, '0, '0, 0, 0);
    do_cycle(1, 0, 1, 26'h000FFFE, 2'b10, 0, '0, '0, 0, 0);
    chk("sign_ext_grant", dut_grant, 0);
    idle(1, 1);
    idle(1, 1);

    // Contention after reset: strict alternation 0,1,0,1.
    do_cycle(0, 0, 0, '0, '0, 0, '0, '0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      do_cycle(1, 0, 1, 26'h100 + 26'(k), 2'b01, 1, 26'h200 + 26'(k), 2'b01, 1, 1);
      chk("contention_grant", dut_grant, exp_seq[k]);
    end
    idle(1, 1);

    // Backpressure on slot 1: slot 0 keeps winning; release refills with no bubble.
    do_cycle(1, 0, 0, '0, '0, 1, 26'h0ABCD, 2'b10, 1, 0);
    for (int k = 0; k < 3; k++) begin
      do_cycle(1, 0, 1, 26'h300 + 26'(k), 2'b01, 1, 26'h0ABCD, 2'b10, 1, 0);
      chk("backpressure_grant", dut_grant, 0);
    end
    do_cycle(1, 0, 0, '0, '0, 1, 26'h08001, 2'b10, 1, 1);
    chk("release_grant", dut_grant, 1);

    // Flush with both buffers FULL; pointer must survive (both eligible -> slot 0).
    do_cycle(1, 0, 1, 26'h444, 2'b01, 0, '0, '0, 1, 0);
    do_cycle(1, 1, 1, 26'h555, 2'b01, 1, 26'h666, 2'b01, 0, 0);
    chk("flush_grant", dut_grant, -1);
    do_cycle(1, 0, 1, 26'h777, 2'b01, 1, 26'h888, 2'b01, 1, 1);
    chk("post_flush_grant", dut_grant, 0);
    idle(1, 1);
    idle(1, 1);

    // Jump index, then reset while both buffers are FULL.
    do_cycle(1, 0, 1, 26'h3FFFFFF, 2'b00, 0, '0, '0, 1, 1);
    do_cycle(1, 0, 0, '0, '0, 1, 26'h3FFFFFF, 2'b00, 0, 0);
    do_cycle(0, 0, 1, 26'h1234, 2'b10, 1, 26'h5678, 2'b10, 0, 0);
    idle(0, 0);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 600; n++) begin
      do_cycle(($urandom_range(0, 99) >= 2) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
               26'($urandom), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
               26'($urandom), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
    end
    idle(1, 1);
    idle(1, 1);
    @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
